// File: rtl/vend_pkg.sv
// Shared command/fault codes and dispense-controller state encoding.
package vend_pkg;

  typedef logic [1:0] vend_cmd_t;
  typedef logic [1:0] flt_code_t;

  localparam vend_cmd_t VEND_NONE     = 2'b00;
  localparam vend_cmd_t VEND_ITEM     = 2'b10;
  localparam vend_cmd_t VEND_ITEM_CHG = 2'b11;

  localparam flt_code_t FLT_NONE  = 2'b00;
  localparam flt_code_t FLT_MOTOR = 2'b01;
  localparam flt_code_t FLT_COIN  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MOTOR      = 3'd1,
    ST_COIN_PULSE = 3'd2,
    ST_COIN_WAIT  = 3'd3,
    ST_DONE       = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  // 01 is reserved and never counts as a command
  function automatic logic cmd_valid(vend_cmd_t c);
    return (c == VEND_ITEM) || (c == VEND_ITEM_CHG);
  endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Vend-result input, actuator handshakes and status outputs of the dispense controller.
interface vend_dispense_ctrl_if;
  import vend_pkg::*;

  vend_cmd_t vend_cmd;
  logic      motor_done;
  logic      coin_sense;
  logic      fault_clr;
  logic      motor_en;
  logic      coin_out;
  logic      busy;
  logic      done;
  logic      fault;
  flt_code_t fault_code;
  logic      ovf;

  modport master (
    output vend_cmd, motor_done, coin_sense, fault_clr,
    input  motor_en, coin_out, busy, done, fault, fault_code, ovf
  );

  modport slave (
    input  vend_cmd, motor_done, coin_sense, fault_clr,
    output motor_en, coin_out, busy, done, fault, fault_code, ovf
  );
endinterface

// File: rtl/vend_cycle_timer.sv
// Restartable saturating cycle counter; expired is high on the LIMIT-th counted cycle.
module vend_cycle_timer #(
  parameter int unsigned LIMIT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt;
    if (clr)                             cnt_d = '0;
    else if (en && (cnt != CW'(LIMIT)))  cnt_d = cnt + CW'(1);
  end

  // cnt holds the cycles already spent, so the flag marks the cycle that completes LIMIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      expired <= 1'b0;
    end else begin
      cnt     <= cnt_d;
      expired <= (cnt_d == CW'(LIMIT - 1));
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Drives item motor and change hopper from vend results, with one-deep command buffer and timeouts.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned PULSE_CYC    = 4,
  parameter int unsigned CHANGE_COINS = 1
) (
  input logic                 clk,
  input logic                 rst,
  vend_dispense_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(CHANGE_COINS + 1);
  localparam int unsigned PW = $clog2(PULSE_CYC + 1);

  state_e        state, state_d;
  logic          pend_v, pend_v_d, pend_chg, pend_chg_d;
  logic          chg, chg_d;
  logic [CW-1:0] rem, rem_d;
  logic [PW-1:0] pulse_cnt, pulse_cnt_d;
  flt_code_t     fault_code_q, fault_code_d;
  logic          ovf_q, ovf_d;
  logic          motor_en_q, coin_out_q, busy_q, done_q, fault_q;
  logic          cmd_v, tmr_clr, tmr_en, tmr_expired;

  vend_cycle_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d      = state;
    pend_v_d     = pend_v;
    pend_chg_d   = pend_chg;
    chg_d        = chg;
    rem_d        = rem;
    pulse_cnt_d  = '0;
    fault_code_d = fault_code_q;
    ovf_d        = ovf_q;
    cmd_v        = cmd_valid(bus.vend_cmd);

    case (state)
      ST_IDLE: begin
        if (pend_v) begin
          state_d    = ST_MOTOR;
          chg_d      = pend_chg;
          rem_d      = CW'(CHANGE_COINS);
          pend_v_d   = cmd_v;
          pend_chg_d = bus.vend_cmd[0];
        end else if (cmd_v) begin
          state_d = ST_MOTOR;
          chg_d   = bus.vend_cmd[0];
          rem_d   = CW'(CHANGE_COINS);
        end
      end
      ST_MOTOR: begin
        if (bus.motor_done) begin
          state_d = chg ? ST_COIN_PULSE : ST_DONE;
        end else if (tmr_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_MOTOR;
        end
      end
      ST_COIN_PULSE: begin
        pulse_cnt_d = pulse_cnt + PW'(1);
        if (pulse_cnt == PW'(PULSE_CYC - 1)) begin
          state_d     = ST_COIN_WAIT;
          pulse_cnt_d = '0;
        end
      end
      ST_COIN_WAIT: begin
        if (bus.coin_sense) begin
          rem_d   = rem - CW'(1);
          state_d = (rem == CW'(1)) ? ST_DONE : ST_COIN_PULSE;
        end else if (tmr_expired) begin
          state_d      = ST_FAULT;
          fault_code_d = FLT_COIN;
        end
      end
      ST_DONE: begin
        if (pend_v) begin
          state_d  = ST_MOTOR;
          chg_d    = pend_chg;
          rem_d    = CW'(CHANGE_COINS);
          pend_v_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: begin
        if (bus.fault_clr) begin
          state_d      = ST_IDLE;
          fault_code_d = FLT_NONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // While executing, a new command fills the empty slot or is lost
    if (cmd_v && (state inside {ST_MOTOR, ST_COIN_PULSE, ST_COIN_WAIT, ST_DONE})) begin
      if (!pend_v) begin
        pend_v_d   = 1'b1;
        pend_chg_d = bus.vend_cmd[0];
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (cmd_v && (state == ST_FAULT)) ovf_d = 1'b1;
    if (state_d == ST_FAULT)          pend_v_d = 1'b0;

    tmr_clr = (state_d != state);
    tmr_en  = (state == ST_MOTOR) || (state == ST_COIN_WAIT);
  end

  // Outputs are registered decodes of the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v       <= 1'b0;
      pend_chg     <= 1'b0;
      chg          <= 1'b0;
      rem          <= '0;
      pulse_cnt    <= '0;
      fault_code_q <= FLT_NONE;
      ovf_q        <= 1'b0;
      motor_en_q   <= 1'b0;
      coin_out_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pend_v       <= pend_v_d;
      pend_chg     <= pend_chg_d;
      chg          <= chg_d;
      rem          <= rem_d;
      pulse_cnt    <= pulse_cnt_d;
      fault_code_q <= fault_code_d;
      ovf_q        <= ovf_d;
      motor_en_q   <= (state_d == ST_MOTOR);
      coin_out_q   <= (state_d == ST_COIN_PULSE);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
      fault_q      <= (state_d == ST_FAULT);
    end
  end

  assign bus.motor_en   = motor_en_q;
  assign bus.coin_out   = coin_out_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fault_code_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl with TIMEOUT_CYC=16, PULSE_CYC=4, CHANGE_COINS=2.
module tb_vend_dispense_ctrl;
  import vend_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  vend_dispense_ctrl_if bus ();

  vend_dispense_ctrl #(
    .TIMEOUT_CYC  (16),
    .PULSE_CYC    (4),
    .CHANGE_COINS (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk1({tag, "_motor_en"}, bus.motor_en, 1'b0);
    chk1({tag, "_coin_out"}, bus.coin_out, 1'b0);
    chk1({tag, "_busy"},     bus.busy,     1'b0);
    chk1({tag, "_done"},     bus.done,     1'b0);
    chk1({tag, "_fault"},    bus.fault,    1'b0);
    chk2({tag, "_fcode"},    bus.fault_code, FLT_NONE);
    chk1({tag, "_ovf"},      bus.ovf,      1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.vend_cmd   = VEND_NONE;
    bus.motor_done = 1'b0;
    bus.coin_sense = 1'b0;
    bus.fault_clr  = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk_idle_zero("reset");

    // Plain vend: cmd at t0, motor_done at t5, DONE at t6, IDLE at t7
    bus.vend_cmd = VEND_ITEM;
    step();
    bus.vend_cmd = VEND_NONE;
    for (int i = 1; i <= 5; i++) begin
      chk1("plain_motor_en", bus.motor_en, 1'b1);
      chk1("plain_coin_out", bus.coin_out, 1'b0);
      chk1("plain_done_early", bus.done, 1'b0);
      if (i == 5) bus.motor_done = 1'b1;
      step();
    end
    bus.motor_done = 1'b0;
    chk1("plain_done", bus.done, 1'b1);
    chk1("plain_motor_off", bus.motor_en, 1'b0);
    chk1("plain_coin_out_done", bus.coin_out, 1'b0);
    step();
    chk1("plain_done_1cyc", bus.done, 1'b0);
    chk1("plain_idle", bus.busy, 1'b0);

    // Reserved code 01 is ignored
    bus.vend_cmd = 2'b01;
    step();
    bus.vend_cmd = VEND_NONE;
    chk1("rsvd_busy", bus.busy, 1'b0);
    chk1("rsvd_ovf", bus.ovf, 1'b0);

    // Change vend: two 4-cycle pulses, coin_sense 2 cycles after each
    bus.vend_cmd = VEND_ITEM_CHG;
    step();
    bus.vend_cmd = VEND_NONE;
    for (int i = 1; i <= 3; i++) begin
      chk1("chg_motor_en", bus.motor_en, 1'b1);
      if (i == 3) bus.motor_done = 1'b1;
      step();
    end
    bus.motor_done = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        chk1("chg_pulse_hi", bus.coin_out, 1'b1);
        chk1("chg_pulse_motor_off", bus.motor_en, 1'b0);
        step();
      end
      chk1("chg_pulse_end", bus.coin_out, 1'b0);
      chk1("chg_wait_busy", bus.busy, 1'b1);
      step();
      bus.coin_sense = 1'b1;
      chk1("chg_wait_no_done", bus.done, 1'b0);
      step();
      bus.coin_sense = 1'b0;
    end
    chk1("chg_done", bus.done, 1'b1);
    chk1("chg_done_coin_off", bus.coin_out, 1'b0);
    step();
    chk1("chg_idle", bus.busy, 1'b0);
    chk1("chg_done_1cyc", bus.done, 1'b0);

    // Motor timeout after 16 MOTOR cycles
    bus.vend_cmd = VEND_ITEM;
    step();
    bus.vend_cmd = VEND_NONE;
    for (int i = 1; i <= 16; i++) begin
      chk1("mto_motor_en", bus.motor_en, 1'b1);
      chk1("mto_no_fault", bus.fault, 1'b0);
      step();
    end
    chk1("mto_fault", bus.fault, 1'b1);
    chk2("mto_fcode", bus.fault_code, FLT_MOTOR);
    chk1("mto_motor_off", bus.motor_en, 1'b0);
    chk1("mto_busy", bus.busy, 1'b1);
    step();
    chk1("mto_fault_held", bus.fault, 1'b1);
    chk2("mto_fcode_held", bus.fault_code, FLT_MOTOR);
    bus.fault_clr = 1'b1;
    step();
    bus.fault_clr = 1'b0;
    chk_idle_zero("mto_clr");

    // coin_sense on the expiry cycle of COIN_WAIT wins over the timeout
    bus.vend_cmd = VEND_ITEM_CHG;
    step();
    bus.vend_cmd   = VEND_NONE;
    bus.motor_done = 1'b1;
    step();
    bus.motor_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk1("exp_pulse1", bus.coin_out, 1'b1);
      step();
    end
    for (int w = 1; w <= 16; w++) begin
      chk1("exp_wait_no_fault", bus.fault, 1'b0);
      chk1("exp_wait_coin_off", bus.coin_out, 1'b0);
      if (w == 16) bus.coin_sense = 1'b1;
      step();
    end
    bus.coin_sense = 1'b0;
    chk1("exp_no_fault", bus.fault, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk1("exp_pulse2", bus.coin_out, 1'b1);
      step();
    end
    bus.coin_sense = 1'b1;
    step();
    bus.coin_sense = 1'b0;
    chk1("exp_done", bus.done, 1'b1);
    chk2("exp_fcode", bus.fault_code, FLT_NONE);
    step();
    chk1("exp_idle", bus.busy, 1'b0);

    // Buffering: first 10 stored, second 10 dropped
    bus.vend_cmd = VEND_ITEM_CHG;
    step();
    bus.vend_cmd = VEND_ITEM;
    step();
    bus.vend_cmd = VEND_NONE;
    chk1("buf_ovf_clear", bus.ovf, 1'b0);
    step();
    bus.vend_cmd = VEND_ITEM;
    step();
    bus.vend_cmd = VEND_NONE;
    chk1("buf_ovf_set", bus.ovf, 1'b1);
    chk1("buf_motor_en", bus.motor_en, 1'b1);
    bus.motor_done = 1'b1;
    step();
    bus.motor_done = 1'b0;
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 4; k++) begin
        chk1("buf_pulse", bus.coin_out, 1'b1);
        step();
      end
      bus.coin_sense = 1'b1;
      step();
      bus.coin_sense = 1'b0;
    end
    chk1("buf_done1", bus.done, 1'b1);
    step();
    chk1("buf_pend_motor", bus.motor_en, 1'b1);
    chk1("buf_pend_busy", bus.busy, 1'b1);
    chk1("buf_pend_done_low", bus.done, 1'b0);
    bus.motor_done = 1'b1;
    step();
    bus.motor_done = 1'b0;
    chk1("buf_done2", bus.done, 1'b1);
    chk1("buf_done2_no_coin", bus.coin_out, 1'b0);
    step();
    chk1("buf_idle", bus.busy, 1'b0);
    chk1("buf_ovf_sticky", bus.ovf, 1'b1);
    step();
    chk1("buf_no_third", bus.busy, 1'b0);
    chk1("buf_motor_stays_off", bus.motor_en, 1'b0);

    // Reset during COIN_PULSE clears everything including ovf
    bus.vend_cmd = VEND_ITEM_CHG;
    step();
    bus.vend_cmd   = VEND_NONE;
    bus.motor_done = 1'b1;
    step();
    bus.motor_done = 1'b0;
    chk1("rst_in_pulse", bus.coin_out, 1'b1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle_zero("rst_mid");
    step();
    chk1("rst_stays_idle", bus.busy, 1'b0);
    bus.vend_cmd = VEND_ITEM;
    step();
    bus.vend_cmd = VEND_NONE;
    chk1("post_rst_motor", bus.motor_en, 1'b1);
    bus.motor_done = 1'b1;
    step();
    bus.motor_done = 1'b0;
    chk1("post_rst_done", bus.done, 1'b1);
    step();
    chk1("post_rst_idle", bus.busy, 1'b0);
    chk1("post_rst_ovf", bus.ovf, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
